// File: rtl/smart_light_pkg.sv
// Shared types and counter-width helpers for the multi-zone lighting controller.
package smart_light_pkg;

  typedef enum logic {MODE_AUTO, MODE_MANUAL} mode_t;

  typedef enum logic [1:0] {EVT_NONE, EVT_SHORT, EVT_LONG} press_evt_t;

  // Bits needed to hold 0..max_val inclusive, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int DEF_DEBOUNCE_CYC    = 4;
  localparam int DEF_LONG_PRESS_CYC  = 8;
  localparam int DEF_OFF_TIMEOUT_CYC = 30;
  localparam int DEF_DEBOUNCE_W      = cnt_width(DEF_DEBOUNCE_CYC);
  localparam int DEF_PRESS_W         = cnt_width(DEF_LONG_PRESS_CYC);
  localparam int DEF_TIMER_W         = cnt_width(DEF_OFF_TIMEOUT_CYC);

endpackage

// File: rtl/input_conditioner.sv
// One raw asynchronous bit: 2-FF synchroniser followed by a consecutive-sample debouncer.
module input_conditioner
  import smart_light_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = cnt_width(DEBOUNCE_CYC);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Any cycle where the synchronised value agrees with the level restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_zone_light_ctrl.sv
// N-zone smart-lighting controller: per-zone press detection, AUTO/MANUAL mode and
// auto-off timer, with a global all-off override.
module multi_zone_light_ctrl
  import smart_light_pkg::*;
#(
  parameter int N_ZONES         = 4,
  parameter int DEBOUNCE_CYC    = 4,
  parameter int LONG_PRESS_CYC  = 8,
  parameter int OFF_TIMEOUT_CYC = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_ZONES-1:0] push_button,
  input  logic [N_ZONES-1:0] infravermelho,
  input  logic               all_off,
  output logic [N_ZONES-1:0] led,
  output logic [N_ZONES-1:0] saida
);

  localparam int PW = cnt_width(LONG_PRESS_CYC);
  localparam int TW = cnt_width(OFF_TIMEOUT_CYC);
  localparam logic [PW-1:0] LONG_MAX = PW'(LONG_PRESS_CYC);
  localparam logic [PW-1:0] LONG_M1  = PW'(LONG_PRESS_CYC - 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(OFF_TIMEOUT_CYC);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);

  for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
    logic          btn_db;
    logic          mot_db;
    logic [PW-1:0] pcnt;
    press_evt_t    evt;
    mode_t         mode, mode_n;
    logic          lamp, lamp_n;
    logic [TW-1:0] tmr, tmr_n;

    input_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
      .clk   (clk),
      .rst   (rst),
      .raw   (push_button[z]),
      .level (btn_db)
    );

    input_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mot (
      .clk   (clk),
      .rst   (rst),
      .raw   (infravermelho[z]),
      .level (mot_db)
    );

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pcnt <= '0;
      end else if (!btn_db) begin
        pcnt <= '0;
      end else if (pcnt != LONG_MAX) begin
        pcnt <= pcnt + 1'b1;
      end
    end

    // A nonzero count with the button now low means this is the release cycle.
    always_comb begin
      evt = EVT_NONE;
      if (btn_db && pcnt == LONG_M1) begin
        evt = EVT_LONG;
      end else if (!btn_db && pcnt != '0 && pcnt != LONG_MAX) begin
        evt = EVT_SHORT;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        mode <= MODE_AUTO;
        lamp <= 1'b0;
        tmr  <= '0;
      end else begin
        mode <= mode_n;
        lamp <= lamp_n;
        tmr  <= tmr_n;
      end
    end

    always_comb begin
      mode_n = mode;
      lamp_n = lamp;
      tmr_n  = tmr;
      if (all_off) begin
        lamp_n = 1'b0;
        tmr_n  = '0;
      end else if (evt == EVT_LONG) begin
        tmr_n = '0;
        if (mode == MODE_AUTO) begin
          mode_n = MODE_MANUAL;
        end else begin
          mode_n = MODE_AUTO;
          lamp_n = 1'b0;
        end
      end else if (mode == MODE_AUTO) begin
        if (mot_db || evt == EVT_SHORT) begin
          lamp_n = 1'b1;
          tmr_n  = TMR_LOAD;
        end else if (tmr != '0) begin
          tmr_n = tmr - 1'b1;
          if (tmr == TMR_ONE) begin
            lamp_n = 1'b0;
          end
        end
      end else begin
        tmr_n = '0;
        if (evt == EVT_SHORT) begin
          lamp_n = ~lamp;
        end
      end
    end

    assign led[z]   = (mode == MODE_MANUAL);
    assign saida[z] = lamp;
  end

endmodule

// File: tb/tb_multi_zone_light_ctrl.sv
// Directed self-checking bench for multi_zone_light_ctrl with default parameters.
module tb_multi_zone_light_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] push_button;
  logic [3:0] infravermelho;
  logic       all_off;
  logic [3:0] led;
  logic [3:0] saida;

  int n_cmp;
  int n_bad;

  multi_zone_light_ctrl #(
    .N_ZONES(4), .DEBOUNCE_CYC(4), .LONG_PRESS_CYC(8), .OFF_TIMEOUT_CYC(30)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .push_button   (push_button),
    .infravermelho (infravermelho),
    .all_off       (all_off),
    .led           (led),
    .saida         (saida)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_button   = 4'($urandom);
      infravermelho = 4'($urandom);
      all_off       = 1'($urandom);
      tick(1);
      n_cmp++;
      if (led !== 4'b0000 || saida !== 4'b0000) begin
        n_bad++;
        $display("[TB] FAIL reset_hold: led=%b saida=%b expected 0000/0000", led, saida);
      end
    end
    push_button = '0; infravermelho = '0; all_off = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(10);
    n_cmp++;
    if (led !== 4'b0000 || saida !== 4'b0000) begin
      n_bad++;
      $display("[TB] FAIL reset_release: led=%b saida=%b expected 0000/0000", led, saida);
    end
  endtask

  task automatic test_auto_zone0();
    infravermelho[0] = 1'b1;
    tick(6);
    n_cmp++;
    if (saida !== 4'b0000) begin
      n_bad++;
      $display("[TB] FAIL auto_pre_on: saida=%b expected 0000", saida);
    end
    tick(1);
    n_cmp++;
    if (saida !== 4'b0001) begin
      n_bad++;
      $display("[TB] FAIL auto_on: saida=%b expected 0001", saida);
    end
    tick(3);
    infravermelho[0] = 1'b0;
    tick(35);
    n_cmp++;
    if (saida !== 4'b0001) begin
      n_bad++;
      $display("[TB] FAIL auto_hold: saida=%b expected 0001", saida);
    end
    tick(1);
    n_cmp++;
    if (saida !== 4'b0000 || led !== 4'b0000) begin
      n_bad++;
      $display("[TB] FAIL auto_off: saida=%b led=%b expected 0000/0000", saida, led);
    end
  endtask

  task automatic test_long_short_zone1();
    push_button[1] = 1'b1;
    tick(13);
    n_cmp++;
    if (led !== 4'b0000) begin
      n_bad++;
      $display("[TB] FAIL long_early: led=%b expected 0000", led);
    end
    tick(1);
    n_cmp++;
    if (led !== 4'b0010) begin
      n_bad++;
      $display("[TB] FAIL long_toggle: led=%b expected 0010", led);
    end
    tick(6);
    push_button[1] = 1'b0;
    tick(10);
    n_cmp++;
    if (led !== 4'b0010 || saida !== 4'b0000) begin
      n_bad++;
      $display("[TB] FAIL long_release: led=%b saida=%b expected 0010/0000", led, saida);
    end
    push_button[1] = 1'b1;
    tick(5);
    push_button[1] = 1'b0;
    tick(6);
    n_cmp++;
    if (saida !== 4'b0000) begin
      n_bad++;
      $display("[TB] FAIL short_early: saida=%b expected 0000", saida);
    end
    tick(1);
    n_cmp++;
    if (saida !== 4'b0010) begin
      n_bad++;
      $display("[TB] FAIL short_on: saida=%b expected 0010", saida);
    end
    tick(4);
    push_button[1] = 1'b1;
    tick(5);
    push_button[1] = 1'b0;
    tick(7);
    n_cmp++;
    if (saida !== 4'b0000 || led !== 4'b0010) begin
      n_bad++;
      $display("[TB] FAIL short_off: saida=%b led=%b expected 0000/0010", saida, led);
    end
  endtask

  task automatic test_bounce_zone2();
    for (int i = 0; i < 10; i++) begin
      push_button[2] = ~push_button[2];
      tick(1);
    end
    tick(20);
    n_cmp++;
    if (led !== 4'b0010 || saida !== 4'b0000) begin
      n_bad++;
      $display("[TB] FAIL bounce: led=%b saida=%b expected 0010/0000", led, saida);
    end
  endtask

  task automatic test_all_off();
    push_button[3] = 1'b1;
    tick(20);
    push_button[3] = 1'b0;
    tick(10);
    push_button[3] = 1'b1;
    tick(5);
    push_button[3] = 1'b0;
    tick(8);
    infravermelho[0] = 1'b1;
    tick(10);
    n_cmp++;
    if (saida !== 4'b1001 || led !== 4'b1010) begin
      n_bad++;
      $display("[TB] FAIL alloff_setup: saida=%b led=%b expected 1001/1010", saida, led);
    end
    all_off = 1'b1;
    tick(1);
    all_off = 1'b0;
    n_cmp++;
    if (saida !== 4'b0000 || led !== 4'b1010) begin
      n_bad++;
      $display("[TB] FAIL alloff_clear: saida=%b led=%b expected 0000/1010", saida, led);
    end
    tick(1);
    n_cmp++;
    if (saida !== 4'b0001) begin
      n_bad++;
      $display("[TB] FAIL alloff_relight: saida=%b expected 0001", saida);
    end
    tick(5);
    n_cmp++;
    if (saida !== 4'b0001 || led !== 4'b1010) begin
      n_bad++;
      $display("[TB] FAIL alloff_after: saida=%b led=%b expected 0001/1010", saida, led);
    end
  endtask

  task automatic test_mid_reset();
    infravermelho[0] = 1'b0;
    tick(21);
    n_cmp++;
    if (saida !== 4'b0001 || led !== 4'b1010) begin
      n_bad++;
      $display("[TB] FAIL midrst_before: saida=%b led=%b expected 0001/1010", saida, led);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (saida !== 4'b0000 || led !== 4'b0000) begin
      n_bad++;
      $display("[TB] FAIL midrst_async: saida=%b led=%b expected 0000/0000", saida, led);
    end
    tick(2);
    rst = 1'b1;
    tick(40);
    n_cmp++;
    if (saida !== 4'b0000 || led !== 4'b0000) begin
      n_bad++;
      $display("[TB] FAIL midrst_after: saida=%b led=%b expected 0000/0000", saida, led);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    push_button = '0;
    infravermelho = '0;
    all_off = 1'b0;
    tick(1);
    test_reset();
    test_auto_zone0();
    test_long_short_zone1();
    test_bounce_zone2();
    test_all_off();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
